wt_dcache_rd_arb: RTL and testbench
===================================

// Module: wt_dcache_rd_arb
// PURPOSE
// - Arbitrates the dcache tag/data array read port among NumPorts requesters (load unit, PTW, write-buffer tag lookup).
// - High-prio ports share it round-robin; low-prio ports get it when high-prio is idle, or forcibly after StarveLimit lost cycles.
// - Blocks all reads while a cacheline refill/invalidation owns the array.
// - Registers the grant so the array-output mux knows the data owner one cycle later.
// PARAMETERS
// NumPorts     3  number of read requesters (>=2)
// StarveLimit  8  consecutive denied cycles before a pending low-prio request is forced (>=1)
// PORTS
// clk_i          in   1                   clock
// rst_i          in   1                   synchronous reset, active high
// rd_req_i       in   NumPorts            read request per port, held until acked
// rd_prio_i      in   NumPorts            1 = high-prio port, 0 = low-prio (quasi-static)
// wr_cl_vld_i    in   1                   refill/invalidate owns array this cycle; no grant
// rd_ack_o       out  NumPorts            one-hot grant, same cycle as request
// rd_gnt_idx_o   out  $clog2(NumPorts)    index of current grant (0 when none)
// rd_gnt_vld_o   out  1                   any grant this cycle
// rd_own_vld_o   out  1                   registered rd_gnt_vld_o (array data valid next cycle)
// rd_own_idx_o   out  $clog2(NumPorts)    registered rd_gnt_idx_o: owner of rd_data
// starve_o       out  1                   starvation counter saturated (forced low-prio grant active)
// BEHAVIOUR
// - Reset (rst_i=1 at clk edge):
//   - hi_ptr=0, lo_ptr=0, starve_cnt=0.
//   - rd_own_vld_o=0, rd_own_idx_o=0, starve_o=0.
//   - rd_ack_o follows combinationally from the reset state.
//   - Reset mid-operation discards the owner register; an outstanding ack is not replayed.
// - Grant (combinational), at most one bit of rd_ack_o set per cycle:
//   1. wr_cl_vld_i=1 -> no grant; rd_ack_o=0.
//   2. Else if starve_cnt==StarveLimit and a low-prio request is pending -> grant low-prio, round-robin from lo_ptr.
//   3. Else if any high-prio request -> grant first high-prio requester at/after hi_ptr (wrapping modulo NumPorts).
//   4. Else if any low-prio request -> grant low-prio, round-robin from lo_ptr.
//   5. Else no grant.
// - Pointer update, on the clock edge after a grant to port g:
//   - class ptr <= (g==NumPorts-1) ? 0 : g+1.
//   - The other class ptr is unchanged.
// - starve_cnt, evaluated each clock:
//   - Cleared when a low-prio port is granted, or when no low-prio request is pending.
//   - Else +1, saturating at StarveLimit.
//   - Increments also while wr_cl_vld_i blocks.
// - starve_o = (starve_cnt==StarveLimit).
// - Owner register: rd_own_vld_o/rd_own_idx_o <= rd_gnt_vld_o/rd_gnt_idx_o every cycle; latency exactly 1.
// - Requesters must keep rd_req_i high until acked. Dropping without an ack is legal and has no side effect except the starve_cnt clear.
// - rd_prio_i changes take effect the same cycle; pointers are not reset.
// - Simultaneous refill and forced starvation: refill wins; starve_cnt stays saturated and the grant happens the first non-blocked cycle.
// TESTING
// - Reset, all req=0 -> rd_ack_o=0, rd_own_vld_o=0, starve_o=0 for 5 cycles.
// - prio=3'b011, req=3'b011 held 4 cycles -> acks 001,010,001,010; rd_own_idx_o lags 1 cycle: x,0,1,0.
// - prio=3'b011, req=3'b111 continuous, StarveLimit=8:
//   - port2 acked on cycle 9 with starve_o=1.
//   - Then counter clears; next ack returns to the high-prio port at hi_ptr.
// - wr_cl_vld_i=1 for 3 cycles with req=3'b001 -> rd_ack_o=0 for those cycles; ack 001 on the 4th; rd_own_vld_o=1 on the 5th.
// - Only port2 (low) requests -> ack 100 same cycle; starve_cnt stays 0.
// - rst_i asserted while req=3'b011 and hi_ptr=1 -> next cycle ack 001 (ptr=0); rd_own_vld_o=0 in the cycle after reset.

Source files
------------

// File: rtl/wt_dcache_rd_arb.sv
// Read-port arbiter for the write-through dcache tag/data arrays.
// High-prio ports share the port round-robin, low-prio ports fill idle cycles or are forced in after a starvation window.
module wt_dcache_rd_arb #(
    parameter int unsigned NumPorts    = 3,
    parameter int unsigned StarveLimit = 8
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic [NumPorts-1:0]         rd_req_i,
    input  logic [NumPorts-1:0]         rd_prio_i,
    input  logic                        wr_cl_vld_i,
    output logic [NumPorts-1:0]         rd_ack_o,
    output logic [$clog2(NumPorts)-1:0] rd_gnt_idx_o,
    output logic                        rd_gnt_vld_o,
    output logic                        rd_own_vld_o,
    output logic [$clog2(NumPorts)-1:0] rd_own_idx_o,
    output logic                        starve_o
);

    localparam int unsigned IdxW = $clog2(NumPorts);
    localparam int unsigned CntW = $clog2(StarveLimit + 1);
    localparam logic [IdxW-1:0] LastIdx = IdxW'(NumPorts - 1);
    localparam logic [CntW-1:0] CntMax  = CntW'(StarveLimit);

    // Handshake: a requester holds rd_req_i until it sees its rd_ack_o bit in the
    // same cycle; the array data for that grant belongs to rd_own_idx_o one cycle later.

    logic [IdxW-1:0]     r_hi_ptr;
    logic [IdxW-1:0]     r_lo_ptr;
    logic [CntW-1:0]     r_starve_cnt;
    logic                r_own_vld;
    logic [IdxW-1:0]     r_own_idx;

    logic [NumPorts-1:0] w_hi_req;
    logic [NumPorts-1:0] w_lo_req;
    logic                w_hi_any;
    logic                w_lo_any;
    logic [IdxW:0]       w_hi_pick;
    logic [IdxW:0]       w_lo_pick;
    logic                w_starved;
    logic                w_gnt_vld;
    logic                w_gnt_lo;
    logic [IdxW-1:0]     w_gnt_idx;
    logic [IdxW-1:0]     w_ptr_next;

    // Returns {found, index} of the first set bit of mask at or after ptr, wrapping.
    function automatic logic [IdxW:0] rr_pick(input logic [NumPorts-1:0] mask,
                                              input logic [IdxW-1:0]     ptr);
        logic          found;
        logic [IdxW:0] res;
        int            j;
        found = 1'b0;
        res   = '0;
        for (int k = 0; k < int'(NumPorts); k++) begin
            j = int'(ptr) + k;
            if (j >= int'(NumPorts)) begin
                j = j - int'(NumPorts);
            end
            if (!found && mask[j]) begin
                found = 1'b1;
                res   = {1'b1, j[IdxW-1:0]};
            end
        end
        return res;
    endfunction

    assign w_hi_req  = rd_req_i & rd_prio_i;
    assign w_lo_req  = rd_req_i & ~rd_prio_i;
    assign w_hi_any  = |w_hi_req;
    assign w_lo_any  = |w_lo_req;
    assign w_hi_pick = rr_pick(w_hi_req, r_hi_ptr);
    assign w_lo_pick = rr_pick(w_lo_req, r_lo_ptr);
    assign w_starved = (r_starve_cnt == CntMax);

    // A refill owns the array outright, even over a saturated starvation counter.
    always_comb begin
        w_gnt_vld = 1'b0;
        w_gnt_lo  = 1'b0;
        w_gnt_idx = '0;
        if (!wr_cl_vld_i) begin
            if (w_starved && w_lo_any) begin
                w_gnt_vld = 1'b1;
                w_gnt_lo  = 1'b1;
                w_gnt_idx = w_lo_pick[IdxW-1:0];
            end else if (w_hi_any) begin
                w_gnt_vld = 1'b1;
                w_gnt_idx = w_hi_pick[IdxW-1:0];
            end else if (w_lo_any) begin
                w_gnt_vld = 1'b1;
                w_gnt_lo  = 1'b1;
                w_gnt_idx = w_lo_pick[IdxW-1:0];
            end
        end
    end

    assign w_ptr_next = (w_gnt_idx == LastIdx) ? '0 : w_gnt_idx + IdxW'(1);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_hi_ptr <= '0;
            r_lo_ptr <= '0;
        end else if (w_gnt_vld) begin
            if (w_gnt_lo) begin
                r_lo_ptr <= w_ptr_next;
            end else begin
                r_hi_ptr <= w_ptr_next;
            end
        end
    end

    // Counts cycles a pending low-prio request loses, including refill-blocked cycles.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_starve_cnt <= '0;
        end else if (!w_lo_any || (w_gnt_vld && w_gnt_lo)) begin
            r_starve_cnt <= '0;
        end else if (!w_starved) begin
            r_starve_cnt <= r_starve_cnt + CntW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_own_vld <= 1'b0;
            r_own_idx <= '0;
        end else begin
            r_own_vld <= w_gnt_vld;
            r_own_idx <= w_gnt_idx;
        end
    end

    assign rd_ack_o     = w_gnt_vld ? (NumPorts'(1) << w_gnt_idx) : '0;
    assign rd_gnt_idx_o = w_gnt_idx;
    assign rd_gnt_vld_o = w_gnt_vld;
    assign rd_own_vld_o = r_own_vld;
    assign rd_own_idx_o = r_own_idx;
    assign starve_o     = w_starved;

endmodule

// File: tb/tb_wt_dcache_rd_arb.sv
// Directed bench for wt_dcache_rd_arb (NumPorts=3, StarveLimit=8).
// Inputs change 1 time unit after the rising edge; outputs are checked 1 unit after that.
module tb_wt_dcache_rd_arb;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic [2:0] rd_req_i;
    logic [2:0] rd_prio_i;
    logic       wr_cl_vld_i;
    logic [2:0] rd_ack_o;
    logic [1:0] rd_gnt_idx_o;
    logic       rd_gnt_vld_o;
    logic       rd_own_vld_o;
    logic [1:0] rd_own_idx_o;
    logic       starve_o;

    int checks   = 0;
    int pass_cnt = 0;
    int fail_cnt = 0;

    wt_dcache_rd_arb #(.NumPorts(3), .StarveLimit(8)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .rd_req_i     (rd_req_i),
        .rd_prio_i    (rd_prio_i),
        .wr_cl_vld_i  (wr_cl_vld_i),
        .rd_ack_o     (rd_ack_o),
        .rd_gnt_idx_o (rd_gnt_idx_o),
        .rd_gnt_vld_o (rd_gnt_vld_o),
        .rd_own_vld_o (rd_own_vld_o),
        .rd_own_idx_o (rd_own_idx_o),
        .starve_o     (starve_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [2:0] exp_ack;

        rst_i       = 1'b1;
        rd_req_i    = 3'b000;
        rd_prio_i   = 3'b000;
        wr_cl_vld_i = 1'b0;
        tick();
        tick();
        rst_i = 1'b0;

        // Idle after reset
        for (int i = 0; i < 5; i++) begin
            settle();
            check("idle_ack", 32'(rd_ack_o), 32'h0);
            check("idle_own_vld", 32'(rd_own_vld_o), 32'h0);
            check("idle_starve", 32'(starve_o), 32'h0);
            tick();
        end

        // Two high-prio ports alternate; owner lags one cycle
        rd_prio_i = 3'b011;
        rd_req_i  = 3'b011;
        for (int i = 0; i < 4; i++) begin
            settle();
            exp_ack = (i % 2 == 0) ? 3'b001 : 3'b010;
            check("hi_rr_ack", 32'(rd_ack_o), 32'(exp_ack));
            check("hi_rr_gnt_idx", 32'(rd_gnt_idx_o), 32'(i % 2));
            tick();
            check("hi_rr_own_vld", 32'(rd_own_vld_o), 32'h1);
            check("hi_rr_own_idx", 32'(rd_own_idx_o), 32'(i % 2));
        end
        rd_req_i = 3'b000;
        tick();
        check("own_vld_clears", 32'(rd_own_vld_o), 32'h0);

        // Continuous requests: low-prio port2 forced in on cycle 9
        rd_req_i = 3'b111;
        for (int c = 1; c <= 10; c++) begin
            settle();
            if (c == 9)       exp_ack = 3'b100;
            else if (c == 10) exp_ack = 3'b001;
            else              exp_ack = (c % 2 == 1) ? 3'b001 : 3'b010;
            check("starve_ack", 32'(rd_ack_o), 32'(exp_ack));
            check("starve_flag", 32'(starve_o), (c == 9) ? 32'h1 : 32'h0);
            tick();
        end
        rd_req_i = 3'b000;
        tick();

        // Refill blocks three cycles, then grant, then owner valid
        rd_req_i    = 3'b001;
        wr_cl_vld_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            settle();
            check("refill_ack", 32'(rd_ack_o), 32'h0);
            check("refill_gnt_vld", 32'(rd_gnt_vld_o), 32'h0);
            tick();
            check("refill_own_vld", 32'(rd_own_vld_o), 32'h0);
        end
        wr_cl_vld_i = 1'b0;
        settle();
        check("post_refill_ack", 32'(rd_ack_o), 32'h1);
        tick();
        check("post_refill_own_vld", 32'(rd_own_vld_o), 32'h1);
        check("post_refill_own_idx", 32'(rd_own_idx_o), 32'h0);
        rd_req_i = 3'b000;
        tick();

        // Refill collides with saturated starvation: refill wins, counter holds
        rd_req_i = 3'b101;
        for (int i = 0; i < 8; i++) begin
            settle();
            check("pre_sat_ack", 32'(rd_ack_o), 32'h1);
            tick();
        end
        wr_cl_vld_i = 1'b1;
        for (int i = 0; i < 2; i++) begin
            settle();
            check("sat_refill_ack", 32'(rd_ack_o), 32'h0);
            check("sat_refill_starve", 32'(starve_o), 32'h1);
            tick();
        end
        wr_cl_vld_i = 1'b0;
        settle();
        check("sat_release_ack", 32'(rd_ack_o), 32'h4);
        tick();
        check("sat_release_clear", 32'(starve_o), 32'h0);
        rd_req_i = 3'b000;
        tick();

        // Only low-prio port2 requests: granted at once, no starvation
        rd_req_i = 3'b100;
        for (int i = 0; i < 2; i++) begin
            settle();
            check("lo_only_ack", 32'(rd_ack_o), 32'h4);
            check("lo_only_starve", 32'(starve_o), 32'h0);
            tick();
        end
        rd_req_i = 3'b000;
        tick();

        // All ports low-prio: round-robin among low requesters from lo_ptr=0
        rd_prio_i = 3'b000;
        rd_req_i  = 3'b101;
        for (int i = 0; i < 3; i++) begin
            settle();
            exp_ack = (i == 1) ? 3'b100 : 3'b001;
            check("lo_rr_ack", 32'(rd_ack_o), 32'(exp_ack));
            tick();
        end
        rd_req_i = 3'b000;
        tick();

        // Reset with hi_ptr=1 returns the grant to port0 and drops the owner
        rd_prio_i = 3'b011;
        rd_req_i  = 3'b011;
        settle();
        check("pre_reset_ack", 32'(rd_ack_o), 32'h2);
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        settle();
        check("post_reset_ack", 32'(rd_ack_o), 32'h1);
        check("post_reset_own_vld", 32'(rd_own_vld_o), 32'h0);
        check("post_reset_starve", 32'(starve_o), 32'h0);
        rd_req_i = 3'b000;
        tick();

        $display("%0d/%0d checks passed", pass_cnt, checks);
        $finish;
    end

endmodule
